// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial 4-bit pattern burst generator; define SEQGEN_LOOP_EN to make reps == 0 start an endless burst
package common;
   typedef enum logic [2:0] {S0, S1, S2, S3, S4} example_states;
endpackage

module seq_pattern_gen #(
   parameter logic [3:0] PATTERN = 4'b1011,
   parameter int         REPS_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [REPS_W-1:0] reps,
   input  logic              abort,
   output logic              dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              done
);
   import common::*;

   example_states     r_state, w_state_next;
   logic [REPS_W-1:0] r_remaining, w_remaining_next;
   logic              r_done, w_done_next;
   logic              w_accept;

`ifdef SEQGEN_LOOP_EN
   assign w_accept = start;
`else
   assign w_accept = start && (reps != '0);
`endif

   // next-state, repetition bookkeeping and done generation; abort overrides everything outside S0
   always_comb begin
      w_state_next     = r_state;
      w_remaining_next = r_remaining;
      w_done_next      = 1'b0;
      case (r_state)
         S0: if (w_accept) begin
            w_state_next     = S1;
            w_remaining_next = reps;
         end
         S1: w_state_next = S2;
         S2: w_state_next = S3;
         S3: w_state_next = S4;
         S4: if (r_remaining == REPS_W'(1)) begin
            w_state_next     = S0;
            w_remaining_next = '0;
            w_done_next      = 1'b1;
         end else if (r_remaining != '0) begin
            w_state_next     = S1;
            w_remaining_next = r_remaining - REPS_W'(1);
         end else begin
`ifdef SEQGEN_LOOP_EN
            w_state_next = S1;
`else
            w_state_next = S0;
`endif
         end
         default: begin
            w_state_next     = S0;
            w_remaining_next = '0;
         end
      endcase
      if (abort && r_state != S0) begin
         w_state_next     = S0;
         w_remaining_next = '0;
         w_done_next      = 1'b0;
      end
   end

   // state, counter and done pulse registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S0;
         r_remaining <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_remaining <= w_remaining_next;
         r_done      <= w_done_next;
      end
   end

   // Moore outputs decoded from the current state
   always_comb begin
      busy       = r_state != S0;
      dout_valid = busy;
      dout       = r_state == S1 ? PATTERN[3] :
                   r_state == S2 ? PATTERN[2] :
                   r_state == S3 ? PATTERN[1] :
                   r_state == S4 ? PATTERN[0] : 1'b0;
      done       = r_done;
   end
endmodule
